// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared widths, pixel level type and PWM compare for the LED-matrix scan driver.
package led_matrix_pkg;
  localparam int DEF_COLS = 8;
  localparam int DEF_ROWS = 8;
  localparam int DEF_PWM_BITS = 2;
  localparam int COL_W = $clog2(DEF_COLS);
  localparam int ROW_W = $clog2(DEF_ROWS);
  localparam int LVL_W = DEF_PWM_BITS;
  localparam int MAX_LVL_W = 4;
  typedef struct packed {
    logic [MAX_LVL_W-1:0] r;
    logic [MAX_LVL_W-1:0] g;
    logic [MAX_LVL_W-1:0] b;
  } rgb_level_t;
  typedef enum logic {IDLE, PENDING} swap_state_t;
  function automatic logic level_lit(input logic [MAX_LVL_W-1:0] level, input logic [MAX_LVL_W-1:0] phase);
    return level > phase;
  endfunction
endpackage

// File: rtl/led_matrix_scan_driver_scan_timer.sv
// led_matrix_scan_driver_scan_timer: slot prescaler, column counter, PWM phase, frame tick, blanking flag.
// Blanking is active only when BLANKING_EN is defined.
module led_matrix_scan_driver_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int SCAN_DIV = 50000,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int BLANK_CYCLES = 16,
  localparam int C_W = $clog2(COLS)
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [C_W-1:0]      col,
  output logic [PWM_BITS-1:0] phase,
  output logic                blank,
  output logic                boundary,
  output logic                frame_tick
);
  localparam int SD_W = $clog2(SCAN_DIV);
  localparam logic [PWM_BITS-1:0] PH_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
`ifdef BLANKING_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif
  logic [SD_W-1:0] slot;
  logic slot_end;
  assign slot_end = slot == SD_W'(SCAN_DIV - 1);
  assign boundary = slot_end && col == C_W'(COLS - 1);
  assign blank = BLANK_ON && (slot < SD_W'(BLANK_CYCLES));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      slot <= '0;
      col <= '0;
      phase <= '0;
      frame_tick <= 1'b0;
    end else begin
      slot <= slot_end ? '0 : slot + 1'b1;
      col <= boundary ? '0 : slot_end ? col + 1'b1 : col;
      // phase is pinned at 0 through blanking so every active window starts at phase 0
      phase <= (slot_end || blank || phase == PH_MAX) ? '0 : phase + 1'b1;
      frame_tick <= boundary;
    end
endmodule

// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: double-buffered RGB LED-matrix column scanner with per-channel PWM.
// Optional anti-ghost blanking at each column slot start via BLANKING_EN.
module led_matrix_scan_driver
  import led_matrix_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int SCAN_DIV = 50000,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int BLANK_CYCLES = 16,
  localparam int C_W = $clog2(COLS),
  localparam int R_W = $clog2(ROWS)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [C_W-1:0]        wr_col,
  input  logic [R_W-1:0]        wr_row,
  input  logic [3*PWM_BITS-1:0] wr_rgb,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_tick,
  output logic [ROWS-1:0]       LightR,
  output logic [ROWS-1:0]       LightG,
  output logic [ROWS-1:0]       LightB,
  output logic [C_W-1:0]        chooseCol,
  output logic                  enable
);
  localparam int L = PWM_BITS;
  logic [3*L-1:0] mem [2][COLS][ROWS];
  logic front, blank, boundary;
  logic [C_W-1:0] col;
  logic [L-1:0] phase;
  logic [ROWS-1:0] lit_r, lit_g, lit_b;
  swap_state_t state;
  rgb_level_t px;
  led_matrix_scan_driver_scan_timer #(
    .COLS(COLS), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS), .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .CLK(CLK), .RST_N(RST_N), .col(col), .phase(phase), .blank(blank),
    .boundary(boundary), .frame_tick(frame_tick)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      front <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= boundary && state == PENDING;
      front <= (boundary && state == PENDING) ? ~front : front;
      // a request landing on the boundary itself re-arms for the following frame
      state <= ((state == PENDING && !boundary) || swap_req) ? PENDING : IDLE;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          for (int r = 0; r < ROWS; r++)
            mem[b][c][r] <= '0;
    end else if (wr_en && {1'b0, wr_col} < (C_W+1)'(COLS) && {1'b0, wr_row} < (R_W+1)'(ROWS))
      mem[~front][wr_col][wr_row] <= wr_rgb;
  always_comb begin
    px = '0;
    lit_r = '0;
    lit_g = '0;
    lit_b = '0;
    for (int r = 0; r < ROWS; r++) begin
      px = '{r: MAX_LVL_W'(mem[front][col][r][3*L-1:2*L]),
             g: MAX_LVL_W'(mem[front][col][r][2*L-1:L]),
             b: MAX_LVL_W'(mem[front][col][r][L-1:0])};
      lit_r[r] = level_lit(px.r, MAX_LVL_W'(phase)) && !blank;
      lit_g[r] = level_lit(px.g, MAX_LVL_W'(phase)) && !blank;
      lit_b[r] = level_lit(px.b, MAX_LVL_W'(phase)) && !blank;
    end
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      LightR <= '1;
      LightG <= '1;
      LightB <= '1;
      chooseCol <= '0;
      enable <= 1'b0;
    end else begin
      LightR <= ~lit_r;
      LightG <= ~lit_g;
      LightB <= ~lit_b;
      chooseCol <= col;
      enable <= 1'b1;
    end
endmodule
